// File: rtl/lsu.sv
// Load/store unit between execute and the data-memory bus; one access in flight at a time.
//
// Ports:
//   clk, rst_n                     core clock, asynchronous active-low reset
//   mem_req/we/size/unsigned/addr/wdata/rd
//                                  memory op offered by execute
//   ld_en, st_en                   acceptance enables from control (low = flush/stall)
//   lsu_ready                      unit idle and able to accept an op
//   misaligned                     one-cycle pulse after an enabled op is rejected for alignment
//   bus_req/we/addr/be/wdata       registered bus request, held until bus_gnt
//   bus_gnt, bus_rvalid, bus_rdata bus handshake and read data
//   ld_valid/ld_rd/ld_data         one-cycle load writeback; rd/data hold until the next load
module lsu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              ld_en,
  input  logic              st_en,
  output logic              lsu_ready,
  output logic              misaligned,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [3:0]        bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              ld_valid,
  output logic [REG_AW-1:0] ld_rd,
  output logic [XLEN-1:0]   ld_data
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [XLEN-1:0]     addr_q;
  logic [3:0]          be_q;
  logic [XLEN-1:0]     wdata_q;
  logic [REG_AW-1:0]   rd_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [1:0]          off_q;
  logic                misaligned_q;
  logic [REG_AW-1:0]   ld_rd_q;
  logic [XLEN-1:0]     ld_data_q;

  logic                aligned;
  logic                enabled;
  logic                offered;
  logic                accept;
  logic [3:0]          be_new;
  logic [XLEN-1:0]     wdata_new;
  logic [XLEN-1:0]     rdata_shifted;
  logic [XLEN-1:0]     rdata_ext;

  // Acceptance decode and store lane steering.
  always_comb begin
    aligned   = 1'b0;
    be_new    = 4'b1111;
    wdata_new = mem_wdata;
    case (mem_size)
      2'b00: begin
        aligned   = 1'b1;
        be_new    = 4'b0001 << mem_addr[1:0];
        wdata_new = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        aligned   = ~mem_addr[0];
        be_new    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{mem_wdata[15:0]}};
      end
      2'b10: begin
        aligned   = (mem_addr[1:0] == 2'b00);
      end
      default: begin
        aligned   = 1'b0;
      end
    endcase
    enabled = mem_we ? st_en : ld_en;
    offered = (state_q == StIdle) && mem_req && enabled;
    accept  = offered && aligned;
  end

  // Load extraction: move the addressed lane down to bit 0, then extend.
  always_comb begin
    rdata_shifted = bus_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   rdata_ext = {{(XLEN-8){~uns_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   rdata_ext = {{(XLEN-16){~uns_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: rdata_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StReq;
      StReq:  if (bus_gnt) state_d = we_q ? StIdle : StWait;  // stores are posted
      StWait: if (bus_rvalid) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      misaligned_q <= 1'b0;
      ld_rd_q      <= '0;
      ld_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= offered && !aligned;
      if (accept) begin
        we_q    <= mem_we;
        addr_q  <= {mem_addr[XLEN-1:2], 2'b00};
        be_q    <= be_new;
        wdata_q <= wdata_new;
        rd_q    <= mem_rd;
        size_q  <= mem_size;
        uns_q   <= mem_unsigned;
        off_q   <= mem_addr[1:0];
      end
      if (state_q == StWait && bus_rvalid) begin
        ld_data_q <= rdata_ext;
        ld_rd_q   <= rd_q;
      end
    end
  end

  assign lsu_ready  = (state_q == StIdle);
  assign misaligned = misaligned_q;
  assign bus_req    = (state_q == StReq);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;
  assign ld_valid   = (state_q == StResp);
  assign ld_rd      = ld_rd_q;
  assign ld_data    = ld_data_q;

endmodule
